recupera_operando_com_sinal: RTL and testbench

//   Inverse of the signed/unsigned mode-coded adder: given an 8-bit sum and the known operand,

---
 rtl/recupera_operando_com_sinal_pkg.sv | 20 ++
 rtl/recupera_operando_com_sinal_subtrator.sv | 13 +
 rtl/recupera_operando_com_sinal.sv | 133 +++++++++++++
 tb/tb_recupera_operando_com_sinal.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/recupera_operando_com_sinal_pkg.sv
// Shared definitions for the serial operand-recovery block:
// mode codes, default widths and FSM state encoding.
package recupera_operando_com_sinal_pkg;

   localparam int LARGURA_PAD       = 8;
   localparam int LARGURA_CURTA_PAD = 4;

   localparam logic [1:0] MODO_SS  = 2'b00;
   localparam logic [1:0] MODO_UU  = 2'b01;
   localparam logic [1:0] MODO_US8 = 2'b10;
   localparam logic [1:0] MODO_US4 = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      CALCULA = 2'b01,
      VALIDA  = 2'b10,
      SAIDA   = 2'b11
   } estado_t;

endpackage

// File: rtl/recupera_operando_com_sinal_subtrator.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module subtrator_completo_1bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/recupera_operando_com_sinal.sv
// Bit-serial recovery of the unknown adder operand (soma - operando),
// LSB first, with a mode-dependent legality flag on the result.
module recupera_operando_com_sinal
   import recupera_operando_com_sinal_pkg::*;
#(
   parameter int LARGURA       = LARGURA_PAD,
   parameter int LARGURA_CURTA = LARGURA_CURTA_PAD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LARGURA-1:0] soma,
   input  logic [LARGURA-1:0] operando,
   input  logic [1:0]         codigo,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LARGURA-1:0] resultado,
   output logic               fora_faixa,
   output logic               emprestimo
);

   localparam int IW = $clog2(LARGURA);
   localparam logic [IW-1:0] ULTIMO = IW'(LARGURA - 1);

   estado_t            r_estado;
   estado_t            w_prox;
   logic [LARGURA-1:0] r_soma;
   logic [LARGURA-1:0] r_op;
   logic [LARGURA-1:0] r_res;
   logic [1:0]         r_cod;
   logic [IW-1:0]      r_idx;
   logic               r_bin;
   logic               r_fora;
   logic               r_emp;
   logic               w_d;
   logic               w_bout;
   logic               w_fora;
   logic               w_ultimo;

   subtrator_completo_1bit u_sub (
      .i_a    (r_soma[0]),
      .i_b    (r_op[0]),
      .i_bin  (r_bin),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   assign w_ultimo   = (r_idx == ULTIMO);
   assign resultado  = r_res;
   assign fora_faixa = r_fora;
   assign emprestimo = r_emp;

   always_ff @(posedge clk) begin
      if (rst) r_estado <= OCIOSO;
      else     r_estado <= w_prox;
   end

   always_comb begin
      w_prox    = r_estado;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_estado)
         OCIOSO: begin
            in_ready = 1'b1;
            if (in_valid) w_prox = CALCULA;
         end
         CALCULA: begin
            if (w_ultimo) w_prox = VALIDA;
         end
         VALIDA: begin
            w_prox = SAIDA;
         end
         SAIDA: begin
            out_valid = 1'b1;
            if (out_ready) w_prox = OCIOSO;
         end
         default: w_prox = OCIOSO;
      endcase
   end

   // A short signed value fits iff all bits from its sign bit up agree.
   always_comb begin
      w_fora = 1'b0;
      case (r_cod)
         MODO_SS, MODO_US4:
            w_fora = !((&r_res[LARGURA-1:LARGURA_CURTA-1]) ||
                       !(|r_res[LARGURA-1:LARGURA_CURTA-1]));
         MODO_UU:
            w_fora = |r_res[LARGURA-1:LARGURA_CURTA];
         default:
            w_fora = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_soma <= '0;
         r_op   <= '0;
         r_res  <= '0;
         r_cod  <= MODO_SS;
         r_idx  <= '0;
         r_bin  <= 1'b0;
         r_fora <= 1'b0;
         r_emp  <= 1'b0;
      end else begin
         unique case (r_estado)
            OCIOSO: begin
               if (in_valid) begin
                  r_soma <= soma;
                  r_op   <= operando;
                  r_cod  <= codigo;
                  r_idx  <= '0;
                  r_bin  <= 1'b0;
               end
            end
            CALCULA: begin
               r_soma <= r_soma >> 1;
               r_op   <= r_op >> 1;
               r_res  <= {w_d, r_res[LARGURA-1:1]};
               r_bin  <= w_bout;
               r_idx  <= r_idx + 1'b1;
               if (w_ultimo) r_emp <= w_bout;
            end
            VALIDA: begin
               r_fora <= w_fora;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_recupera_operando_com_sinal.sv
// Self-checking bench: directed cases, backpressure, mid-run reset
// and randomized transactions against an arithmetic model.
module tb_recupera_operando_com_sinal;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] soma;
   logic [7:0] operando;
   logic [1:0] codigo;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] resultado;
   logic       fora_faixa;
   logic       emprestimo;

   int n_cmp = 0;
   int n_err = 0;

   recupera_operando_com_sinal dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .soma       (soma),
      .operando   (operando),
      .codigo     (codigo),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .resultado  (resultado),
      .fora_faixa (fora_faixa),
      .emprestimo (emprestimo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction and range test on the value.
   function automatic void modelo(input logic [7:0] s, input logic [7:0] o,
                                  input logic [1:0] c,
                                  output logic [7:0] r, output logic f,
                                  output logic e);
      int dif;
      int sr;
      dif = int'(s) - int'(o);
      e   = (dif < 0);
      if (dif < 0) dif = dif + 256;
      r   = dif[7:0];
      sr  = (dif >= 128) ? dif - 256 : dif;
      case (c)
         2'd0, 2'd3: f = (sr < -8) || (sr > 7);
         2'd1:       f = (dif > 15);
         default:    f = 1'b0;
      endcase
   endfunction

   task automatic transacao(input logic [7:0] s, input logic [7:0] o,
                            input logic [1:0] c, input int espera,
                            output logic [7:0] obs_r,
                            output logic obs_f, output logic obs_e);
      logic [7:0] er;
      logic       ef;
      logic       ee;
      int         n;
      modelo(s, o, c, er, ef, ee);
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      soma     = s;
      operando = o;
      codigo   = c;
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      soma     = 8'($urandom);
      operando = 8'($urandom);
      codigo   = 2'($urandom);
      chk("in_ready_busy", in_ready, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 9);
      chk("resultado", resultado, er);
      chk("fora_faixa", fora_faixa, ef);
      chk("emprestimo", emprestimo, ee);
      obs_r = resultado;
      obs_f = fora_faixa;
      obs_e = emprestimo;
      for (int k = 0; k < espera; k++) begin
         in_valid = 1'b1;
         soma     = 8'($urandom);
         codigo   = 2'($urandom);
         @(posedge clk);
         #1;
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 0);
         chk("stall_res", {resultado, fora_faixa, emprestimo}, {er, ef, ee});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("handoff_valid", out_valid, 0);
      chk("handoff_ready", in_ready, 1);
   endtask

   initial begin
      logic [7:0] r;
      logic       f;
      logic       e;
      int         n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      soma      = '0;
      operando  = '0;
      codigo    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_resultado", resultado, 0);
      chk("rst_fora", fora_faixa, 0);
      chk("rst_emp", emprestimo, 0);
      @(negedge clk);
      rst = 1'b0;

      transacao(8'hFD, 8'h05, 2'b00, 0, r, f, e);
      chk("d0_res", r, 8'hF8);
      chk("d0_fora", f, 0);
      transacao(8'h10, 8'h00, 2'b00, 1, r, f, e);
      chk("d1_res", r, 8'h10);
      chk("d1_fora", f, 1);
      transacao(8'h05, 8'hFE, 2'b01, 0, r, f, e);
      chk("d2_res", r, 8'h07);
      chk("d2_fora", f, 0);
      chk("d2_emp", e, 1);
      transacao(8'h00, 8'h01, 2'b10, 0, r, f, e);
      chk("d3_res", r, 8'hFF);
      chk("d3_fora", f, 0);
      transacao(8'h80, 8'h7F, 2'b11, 0, r, f, e);
      chk("d4_res", r, 8'h01);
      chk("d4_fora", f, 0);

      transacao(8'h3C, 8'h11, 2'b01, 5, r, f, e);
      @(posedge clk);
      #1;
      chk("no_accept_on_handoff", in_ready, 1);

      @(negedge clk);
      in_valid = 1'b1;
      soma     = 8'hFF;
      operando = 8'h00;
      codigo   = 2'b10;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_busy", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_resultado", resultado, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      transacao(8'h22, 8'h27, 2'b00, 2, r, f, e);
      chk("post_rst_res", r, 8'hFB);

      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(0, 3);
         transacao(8'($urandom), 8'($urandom), 2'($urandom), n, r, f, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
